// File: rtl/frame_buf_pkg.sv
// Shared definitions for the ping-pong frame buffer: default geometry, writer
// state encoding and a saturating counter helper.
package frame_buf_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 14;
    localparam int unsigned DEF_FRAME_WORDS = 10240;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_FILL     = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_pingpong_writer.sv
// Captures a pixel-word stream into one of two frame buffers and hands full
// buffers to the SPI stage, dropping frames while both buffers are occupied.
module frame_pingpong_writer
    import frame_buf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  pix_valid,
    input  logic [15:0]           pix_data,
    input  logic                  frame_busy,
    output logic                  frame_ready,
    output logic                  buf_sel,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [15:0]           rd_data,
    output logic [ADDR_WIDTH-1:0] ram0_addr,
    output logic [ADDR_WIDTH-1:0] ram1_addr,
    output logic [15:0]           ram_wdata,
    output logic                  ram0_we,
    output logic                  ram1_we,
    input  logic [15:0]           ram0_rdata,
    input  logic [15:0]           ram1_rdata,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            short_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

    state_t                  state;
    logic                    wr_buf;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    guard;

    logic                    can_handoff;
    logic                    wr_now;
    logic [ADDR_WIDTH-1:0]   wr_addr_eff;

    always_comb begin
        can_handoff = !frame_busy && !guard;
        // The sof-cycle word is written at address 0 both on a fresh start and on a restart.
        wr_now      = !rst && pix_valid &&
                      ((state == ST_FILL) || ((state == ST_WAIT_SOF) && sof));
        wr_addr_eff = sof ? '0 : wr_addr;
        ram0_addr   = wr_buf ? rd_addr : wr_addr_eff;
        ram1_addr   = wr_buf ? wr_addr_eff : rd_addr;
        ram0_we     = wr_now && !wr_buf;
        ram1_we     = wr_now && wr_buf;
        ram_wdata   = pix_data;
        rd_data     = buf_sel ? ram1_rdata : ram0_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_WAIT_SOF;
            wr_buf      <= 1'b0;
            buf_sel     <= 1'b0;
            wr_addr     <= '0;
            guard       <= 1'b0;
            frame_ready <= 1'b0;
            drop_cnt    <= '0;
            short_cnt   <= '0;
        end else begin
            frame_ready <= 1'b0;
            guard       <= 1'b0;
            case (state)
                ST_WAIT_SOF: begin
                    if (sof) begin
                        state   <= ST_FILL;
                        wr_addr <= pix_valid ? ADDR_WIDTH'(1) : '0;
                    end
                end
                ST_FILL: begin
                    if (sof) begin
                        short_cnt <= sat_inc8(short_cnt);
                        wr_addr   <= pix_valid ? ADDR_WIDTH'(1) : '0;
                    end else if (pix_valid) begin
                        if (wr_addr == LAST_ADDR) begin
                            wr_addr <= '0;
                            if (can_handoff) begin
                                frame_ready <= 1'b1;
                                buf_sel     <= wr_buf;
                                wr_buf      <= !wr_buf;
                                guard       <= 1'b1;
                                state       <= ST_WAIT_SOF;
                            end else begin
                                state <= ST_HOLD;
                            end
                        end else begin
                            wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (can_handoff) begin
                        frame_ready <= 1'b1;
                        buf_sel     <= wr_buf;
                        wr_buf      <= !wr_buf;
                        guard       <= 1'b1;
                        wr_addr     <= '0;
                        // A sof coinciding with the release starts the next frame instead of being dropped.
                        state       <= sof ? ST_FILL : ST_WAIT_SOF;
                    end else if (sof) begin
                        drop_cnt <= sat_inc8(drop_cnt);
                    end
                end
                default: state <= ST_WAIT_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pingpong_writer.sv
// Self-checking bench for frame_pingpong_writer with a 16-word frame and a
// behavioural model of both frame buffers.
module tb_frame_pingpong_writer;

    localparam int unsigned AW = 4;
    localparam int unsigned FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic [15:0]   pix_data = '0;
    logic          frame_busy = 1'b0;
    logic          frame_ready;
    logic          buf_sel;
    logic [AW-1:0] rd_addr = '0;
    logic [15:0]   rd_data;
    logic [AW-1:0] ram0_addr;
    logic [AW-1:0] ram1_addr;
    logic [15:0]   ram_wdata;
    logic          ram0_we;
    logic          ram1_we;
    logic [15:0]   ram0_rdata;
    logic [15:0]   ram1_rdata;
    logic [7:0]    drop_cnt;
    logic [7:0]    short_cnt;

    logic [15:0] mem0 [FW];
    logic [15:0] mem1 [FW];

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        exp_q [$];
    logic        prev_ready = 1'b0;
    logic        exp_sel_pop;

    typedef struct {
        int unsigned phase;
        logic [3:0]  addr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [8];

    frame_pingpong_writer #(
        .ADDR_WIDTH (AW),
        .FRAME_WORDS(FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .frame_busy (frame_busy),
        .frame_ready(frame_ready),
        .buf_sel    (buf_sel),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ram0_addr  (ram0_addr),
        .ram1_addr  (ram1_addr),
        .ram_wdata  (ram_wdata),
        .ram0_we    (ram0_we),
        .ram1_we    (ram1_we),
        .ram0_rdata (ram0_rdata),
        .ram1_rdata (ram1_rdata),
        .drop_cnt   (drop_cnt),
        .short_cnt  (short_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram0_we) mem0[ram0_addr] <= ram_wdata;
        if (ram1_we) mem1[ram1_addr] <= ram_wdata;
    end
    assign ram0_rdata = mem0[ram0_addr];
    assign ram1_rdata = mem1[ram1_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer for handoff pulses plus the write-protection invariant.
    always @(negedge clk) begin
        if (frame_ready) begin
            if (prev_ready) begin
                checks++;
                errors++;
                $display("FAIL back_to_back: frame_ready high two cycles in a row, expected isolated pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: frame_ready=1 buf_sel=%0d, expected no pulse", buf_sel);
            end else begin
                exp_sel_pop = exp_q.pop_front();
                if (buf_sel !== exp_sel_pop) begin
                    errors++;
                    $display("FAIL pulse_buf_sel: got %0d expected %0d", buf_sel, exp_sel_pop);
                end
            end
        end
        prev_ready = frame_ready;
        if (frame_busy) begin
            checks++;
            if ((ram0_we && !buf_sel) || (ram1_we && buf_sel)) begin
                errors++;
                $display("FAIL busy_write: we0=%0d we1=%0d buf_sel=%0d, expected no write to streamed bank",
                         ram0_we, ram1_we, buf_sel);
            end
        end
    end

    task automatic step(input logic s, input logic v, input logic [15:0] d);
        sof       = s;
        pix_valid = v;
        pix_data  = d;
        @(posedge clk);
        #1;
        sof       = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base, input int unsigned gap, input logic with_sof,
                              input int unsigned busy_n, input logic expect_pulse, input logic exp_sel);
        for (int unsigned i = 0; i < FW; i++) begin
            frame_busy = (i < busy_n);
            if (i == FW - 1 && expect_pulse) exp_q.push_back(exp_sel);
            step(with_sof && (i == 0), 1'b1, base + 16'(i));
            if (i != FW - 1) begin
                for (int unsigned g = 0; g < gap; g++) step(1'b0, 1'b0, '0);
            end
        end
        if (expect_pulse) begin
            check("ready_latency", {31'b0, frame_ready}, 32'd1);
            check("ready_buf_sel", {31'b0, buf_sel}, {31'b0, exp_sel});
        end else begin
            check("no_pulse_when_busy", {31'b0, frame_ready}, 32'd0);
        end
    endtask

    task automatic check_mem(input logic bank, input logic [15:0] base);
        int unsigned bad;
        bad = 0;
        for (int unsigned i = 0; i < FW; i++) begin
            if ((bank ? mem1[i] : mem0[i]) !== base + 16'(i)) bad++;
        end
        check(bank ? "ram1_contents_bad_words" : "ram0_contents_bad_words", bad, 32'd0);
    endtask

    task automatic run_table(input int unsigned ph);
        for (int unsigned k = 0; k < 8; k++) begin
            if (tbl[k].phase == ph) begin
                rd_addr = tbl[k].addr;
                #1;
                check("rd_data", {16'b0, rd_data}, {16'b0, tbl[k].exp});
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_we;
        tbl[0] = '{0, 4'd0,  16'h0000};
        tbl[1] = '{0, 4'd5,  16'h0005};
        tbl[2] = '{0, 4'd9,  16'h0009};
        tbl[3] = '{0, 4'd15, 16'h000F};
        tbl[4] = '{1, 4'd0,  16'h0600};
        tbl[5] = '{1, 4'd3,  16'h0603};
        tbl[6] = '{1, 4'd12, 16'h060C};
        tbl[7] = '{1, 4'd15, 16'h060F};

        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("rst_frame_ready", {31'b0, frame_ready}, 32'd0);
        check("rst_buf_sel", {31'b0, buf_sel}, 32'd0);
        check("rst_we", {30'b0, ram0_we, ram1_we}, 32'd0);
        check("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
        check("rst_short_cnt", {24'b0, short_cnt}, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, '0);

        // Single frame into ram0.
        send_frame(16'h0000, 0, 1'b1, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0);
        check("ready_single_cycle", {31'b0, frame_ready}, 32'd0);
        check_mem(1'b0, 16'h0000);
        run_table(0);

        // Busy consumer: frame 2 into ram1 held, two dropped frames, then release.
        send_frame(16'h0100, 0, 1'b1, FW, 1'b0, 1'b0);
        check_mem(1'b1, 16'h0100);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("drop_cnt_two", {24'b0, drop_cnt}, 32'd2);
        frame_busy = 1'b0;
        exp_q.push_back(1'b1);
        step(1'b0, 1'b0, '0);
        check("release_ready", {31'b0, frame_ready}, 32'd1);
        check("release_buf_sel", {31'b0, buf_sel}, 32'd1);
        step(1'b0, 1'b0, '0);

        // Short frame: 5 words, restart, full frame into ram0.
        for (int unsigned i = 0; i < 5; i++) step(i == 0, 1'b1, 16'h0200 + 16'(i));
        send_frame(16'h0300, 0, 1'b1, 0, 1'b1, 1'b0);
        check("short_cnt_one", {24'b0, short_cnt}, 32'd1);
        check_mem(1'b0, 16'h0300);
        step(1'b0, 1'b0, '0);

        // Release coincident with sof while holding.
        send_frame(16'h0400, 0, 1'b1, FW, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("drop_cnt_three", {24'b0, drop_cnt}, 32'd3);
        frame_busy = 1'b0;
        exp_q.push_back(1'b1);
        step(1'b1, 1'b0, '0);
        check("coincident_ready", {31'b0, frame_ready}, 32'd1);
        check("coincident_buf_sel", {31'b0, buf_sel}, 32'd1);
        check("coincident_drop_cnt", {24'b0, drop_cnt}, 32'd3);
        send_frame(16'h0500, 0, 1'b0, FW, 1'b0, 1'b0);
        frame_busy = 1'b0;
        exp_q.push_back(1'b0);
        step(1'b0, 1'b0, '0);
        check("fill_after_coincident_ready", {31'b0, frame_ready}, 32'd1);
        step(1'b0, 1'b0, '0);
        check_mem(1'b0, 16'h0500);
        check_mem(1'b1, 16'h0400);

        // Gapped input with a busy consumer early, then overrun words.
        send_frame(16'h0600, 2, 1'b1, 12, 1'b1, 1'b1);
        any_we = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            pix_valid = 1'b1;
            pix_data  = 16'hDEA0 + 16'(k);
            #1;
            any_we = any_we | ram0_we | ram1_we;
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
        end
        check("overrun_we", {31'b0, any_we}, 32'd0);
        check_mem(1'b1, 16'h0600);
        check_mem(1'b0, 16'h0500);
        run_table(1);

        // Reset mid-frame after word 7.
        for (int unsigned i = 0; i < 8; i++) step(i == 0, 1'b1, 16'h0700 + 16'(i));
        rst = 1'b1;
        step(1'b0, 1'b0, '0);
        check("midrst_frame_ready", {31'b0, frame_ready}, 32'd0);
        check("midrst_buf_sel", {31'b0, buf_sel}, 32'd0);
        check("midrst_we", {30'b0, ram0_we, ram1_we}, 32'd0);
        check("midrst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
        check("midrst_short_cnt", {24'b0, short_cnt}, 32'd0);
        rst = 1'b0;
        any_we = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            pix_valid = 1'b1;
            pix_data  = 16'h0708 + 16'(k);
            #1;
            any_we = any_we | ram0_we | ram1_we;
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
        end
        check("post_rst_no_write", {31'b0, any_we}, 32'd0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("pending_pulses", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
